shdw_dump_rx: RTL and testbench
===============================

// Module: shdw_dump_rx
// PURPOSE
//  Hardware FSL peer of the SPARC shadow-dump bridge; stands where MicroBlaze would on the FSL pair.
//  Encodes control commands onto FSL, decodes the returned stream (START/data/DONE/0xDEAD status).
//  Stores the dump in a local RAM for host/debug readback; enables bench and MicroBlaze-less operation.
// PARAMETERS
//  BUF_AW       10    dump RAM address width; capacity 2**BUF_AW 32-bit words
//  TIMEOUT_CYC  4096  idle cycles in DUMP before abort (only with SHDW_RX_TIMEOUT_EN)
// PORTS
//  clk          in   1        single clock
//  rst          in   1        synchronous, active-high reset
//  cmd_valid    in   1        command request
//  cmd_ready    out  1        command accepted when cmd_valid & cmd_ready
//  cmd_err_en   in   1        -> word bit1
//  cmd_err_ctrl in   12       -> word bits13:2
//  cmd_sh_rst   in   1        -> word bit14
//  cmd_c_en     in   1        -> word bit15
//  cmd_d_en     in   1        -> word bit16
//  fsl_m_data   out  32       command word to bridge
//  fsl_m_ctrl   out  1        always 0
//  fsl_m_write  out  1        one-cycle push
//  fsl_m_full   in   1        bridge FIFO full
//  fsl_s_read   out  1        pop; = fsl_s_exists & ~rst (combinational)
//  fsl_s_data   in   32       returned word
//  fsl_s_ctrl   in   1        returned control flag
//  fsl_s_exists in   1        returned word available
//  rd_addr      in   BUF_AW   readback address
//  rd_data      out  32       RAM word, 1-cycle latency
//  dump_count   out  BUF_AW+1 words stored this dump
//  dump_busy    out  1        state ARMED or DUMP
//  dump_done    out  1        state DONE
//  overflow     out  1        sticky: data dropped, RAM full
//  status_word  out  32       last 0xDEAD status word
//  status_vld   out  1        one-cycle pulse on status capture
//  timeout      out  1        sticky watchdog abort (0 when macro off)
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM IDLE; tx holding reg empty.
//  TX: cmd_ready = ~tx_pend. Accept latches {15'b0,d_en,c_en,sh_rst,err_ctrl,err_en,1'b1}.
//   fsl_m_write=1 for exactly one cycle when tx_pend & ~fsl_m_full; tx_pend clears same edge.
//   Accept-to-write latency 1 cycle if not full; held indefinitely while full.
//  RX decode (per popped word, sampled on the edge fsl_s_read is high):
//   ctrl=1 & data[31:16]==16'hDEAD -> status_word<=data, status_vld pulse; any state, no FSM effect.
//   ctrl=0 & data==32'hF0000001 -> START (only in ARMED; else ignored).
//   ctrl=1 & data==32'hF0000002 -> DONE (only in DUMP; else ignored).
//   other ctrl=0 in DUMP -> data word; incl. F0000001 (DUMP takes it as data). Else dropped.
//  FSM IDLE/ARMED/DUMP/DONE:
//   Pushed cmd with d_en=1: from any state -> ARMED; clears dump_count, overflow, timeout.
//   Pushed cmd with d_en=0: ARMED/DUMP -> IDLE; RAM and count retained; DONE stays DONE.
//   ARMED --START--> DUMP; DUMP --DONE--> DONE; DONE holds until next cmd push.
//   FSM transitions taken at the fsl_m_write edge, not at cmd accept.
//  Storage: data word written at addr dump_count; count++. If count==2**BUF_AW: drop, overflow<=1, count saturates.
//  Simultaneous cmd push and RX word same edge: cmd transition wins; RX word decoded in new state.
//  Reset mid-dump: immediate IDLE, count 0; RAM content undefined-but-stale.
// CONFIGURATION
//  SHDW_RX_TIMEOUT_EN defined: counter runs in DUMP, clears on each popped word.
//   Reaching TIMEOUT_CYC -> timeout<=1, FSM->IDLE.
//  Undefined: no counter; timeout tied 0; DUMP waits forever.
// STRUCTURE
//  Package shdw_fsl_pkg: FSL_CTRL_DUMP_START/DONE/IDLE consts, STATUS_TAG 16'hDEAD, cmd bit positions.
//  Package also holds FSM state encoding.
//  Sub-module shdw_dump_ram: simple dual-port 2**BUF_AW x 32, sync write, registered read.
// TESTING
//  Reset then cmd d_en=1,c_en=1, full=0 -> next cycle write=1, data=32'h00018001, ctrl=0; dump_busy=1.
//  fsl_m_full=1 for 5 cycles after accept -> no write, cmd_ready=0; write on 1st cycle full=0.
//  START, 3 words A,B,C, DONE(ctrl=1) -> dump_done=1, count=3, rd_addr 0..2 give A,B,C.
//  BUF_AW=2: START + 6 words -> count=4, overflow=1, words 5-6 absent; next d_en=1 cmd clears both.
//  Word {16'hDEAD,16'h1234} ctrl=1 mid-dump -> status_vld pulse, status_word latched, count unchanged.
//  Macro on, TIMEOUT_CYC=16: START, no words 16 cycles -> timeout=1, IDLE.
//  Macro off, same stimulus: stays DUMP.

Source files
------------

// File: rtl/shdw_fsl_pkg.sv
// Shared FSL constants, command-word layout and receiver FSM encoding
// for the shadow-dump receiver.
package shdw_fsl_pkg;

  localparam logic [31:0] FSL_CTRL_DUMP_START = 32'hF000_0001;
  localparam logic [31:0] FSL_CTRL_DUMP_DONE  = 32'hF000_0002;
  localparam logic [31:0] FSL_CTRL_IDLE       = 32'hF000_0000;
  localparam logic [15:0] STATUS_TAG          = 16'hDEAD;

  localparam int unsigned CMD_VLD_BIT      = 0;
  localparam int unsigned CMD_ERR_EN_BIT   = 1;
  localparam int unsigned CMD_ERR_CTRL_LSB = 2;
  localparam int unsigned CMD_SH_RST_BIT   = 14;
  localparam int unsigned CMD_C_EN_BIT     = 15;
  localparam int unsigned CMD_D_EN_BIT     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] build_cmd(input logic        err_en,
                                            input logic [11:0] err_ctrl,
                                            input logic        sh_rst,
                                            input logic        c_en,
                                            input logic        d_en);
    logic [31:0] w;
    w                            = '0;
    w[CMD_VLD_BIT]               = 1'b1;
    w[CMD_ERR_EN_BIT]            = err_en;
    w[CMD_ERR_CTRL_LSB +: 12]    = err_ctrl;
    w[CMD_SH_RST_BIT]            = sh_rst;
    w[CMD_C_EN_BIT]              = c_en;
    w[CMD_D_EN_BIT]              = d_en;
    return w;
  endfunction

endpackage

// File: rtl/shdw_dump_ram.sv
// Simple dual-port dump buffer: 2**AW x 32, synchronous write,
// registered read (one cycle latency, cleared by reset).
module shdw_dump_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [2**AW];

  // Write port
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/shdw_dump_rx.sv
// Hardware FSL peer of the shadow-dump bridge: pushes control commands,
// decodes the returned START/data/DONE/status stream and stores the dump.
// Optional watchdog on DUMP enabled by defining SHDW_RX_TIMEOUT_EN.
module shdw_dump_rx
  import shdw_fsl_pkg::*;
#(
  parameter int unsigned BUF_AW      = 10,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_err_en,
  input  logic [11:0]       cmd_err_ctrl,
  input  logic              cmd_sh_rst,
  input  logic              cmd_c_en,
  input  logic              cmd_d_en,
  output logic [31:0]       fsl_m_data,
  output logic              fsl_m_ctrl,
  output logic              fsl_m_write,
  input  logic              fsl_m_full,
  output logic              fsl_s_read,
  input  logic [31:0]       fsl_s_data,
  input  logic              fsl_s_ctrl,
  input  logic              fsl_s_exists,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [BUF_AW:0]   dump_count,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              overflow,
  output logic [31:0]       status_word,
  output logic              status_vld,
  output logic              timeout
);

  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  rx_state_t        r_state, w_state_nxt;
  logic             r_tx_pend;
  logic [31:0]      r_tx_data;
  logic [BUF_AW:0]  r_count, w_count_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_accept, w_push, w_ram_we, w_status_cap, w_tmo_hit;

  assign cmd_ready   = ~r_tx_pend;
  assign w_accept    = cmd_valid & ~r_tx_pend;
  assign w_push      = r_tx_pend & ~fsl_m_full;
  assign fsl_m_write = w_push;
  assign fsl_m_data  = r_tx_data;
  assign fsl_m_ctrl  = 1'b0;
  assign fsl_s_read  = fsl_s_exists & ~rst;
  assign dump_count  = r_count;
  assign dump_busy   = (r_state == ST_ARMED) || (r_state == ST_DUMP);
  assign dump_done   = (r_state == ST_DONE);
  assign overflow    = r_ovf;
  assign timeout     = r_timeout;

  // Command holding register: one word in flight toward the bridge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_pend <= 1'b0;
      r_tx_data <= '0;
    end else if (w_accept) begin
      r_tx_pend <= 1'b1;
      r_tx_data <= build_cmd(cmd_err_en, cmd_err_ctrl, cmd_sh_rst, cmd_c_en, cmd_d_en);
    end else if (w_push) begin
      r_tx_pend <= 1'b0;
    end
  end

`ifdef SHDW_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Idle watchdog: counts DUMP cycles without a popped word
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_DUMP) || fsl_s_read) r_to_cnt <= '0;
    else                                           r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_tmo_hit = (r_state == ST_DUMP) && !fsl_s_read &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC == 0);
  assign w_tmo_hit   = 1'b0;
`endif

  // Next state: watchdog, then command push, then RX word decoded in the
  // post-command state so a same-edge command always takes precedence.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_ovf_nxt     = r_ovf;
    w_timeout_nxt = r_timeout;
    w_ram_we      = 1'b0;
    w_status_cap  = 1'b0;
    if (w_tmo_hit) begin
      w_state_nxt   = ST_IDLE;
      w_timeout_nxt = 1'b1;
    end
    if (w_push) begin
      if (r_tx_data[CMD_D_EN_BIT]) begin
        w_state_nxt   = ST_ARMED;
        w_count_nxt   = '0;
        w_ovf_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
      end else if ((w_state_nxt == ST_ARMED) || (w_state_nxt == ST_DUMP)) begin
        w_state_nxt = ST_IDLE;
      end
    end
    if (fsl_s_read) begin
      if (fsl_s_ctrl && (fsl_s_data[31:16] == STATUS_TAG)) begin
        w_status_cap = 1'b1;
      end else if (!fsl_s_ctrl && (fsl_s_data == FSL_CTRL_DUMP_START) &&
                   (w_state_nxt == ST_ARMED)) begin
        w_state_nxt = ST_DUMP;
      end else if (fsl_s_ctrl && (fsl_s_data == FSL_CTRL_DUMP_DONE) &&
                   (w_state_nxt == ST_DUMP)) begin
        w_state_nxt = ST_DONE;
      end else if (!fsl_s_ctrl && (w_state_nxt == ST_DUMP)) begin
        if (r_count == DEPTH) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_ram_we    = 1'b1;
          w_count_nxt = r_count + 1'b1;
        end
      end
    end
  end

  // FSM, dump bookkeeping and status capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_timeout   <= 1'b0;
      status_word <= '0;
      status_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_ovf      <= w_ovf_nxt;
      r_timeout  <= w_timeout_nxt;
      status_vld <= w_status_cap;
      if (w_status_cap) status_word <= fsl_s_data;
    end
  end

  shdw_dump_ram #(.AW(BUF_AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_ram_we),
    .waddr (r_count[BUF_AW-1:0]),
    .wdata (fsl_s_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_shdw_dump_rx.sv
// Directed self-checking bench for shdw_dump_rx (BUF_AW=2, TIMEOUT_CYC=16).
module tb_shdw_dump_rx;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_err_en, cmd_sh_rst, cmd_c_en, cmd_d_en;
  logic [11:0]   cmd_err_ctrl;
  logic [31:0]   fsl_m_data, fsl_s_data, rd_data, status_word;
  logic          fsl_m_ctrl, fsl_m_write, fsl_m_full, fsl_s_read, fsl_s_ctrl, fsl_s_exists;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   dump_count;
  logic          dump_busy, dump_done, overflow, status_vld, timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  shdw_dump_rx #(.BUF_AW(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_err_en(cmd_err_en),
    .cmd_err_ctrl(cmd_err_ctrl), .cmd_sh_rst(cmd_sh_rst), .cmd_c_en(cmd_c_en),
    .cmd_d_en(cmd_d_en), .fsl_m_data(fsl_m_data), .fsl_m_ctrl(fsl_m_ctrl),
    .fsl_m_write(fsl_m_write), .fsl_m_full(fsl_m_full), .fsl_s_read(fsl_s_read),
    .fsl_s_data(fsl_s_data), .fsl_s_ctrl(fsl_s_ctrl), .fsl_s_exists(fsl_s_exists),
    .rd_addr(rd_addr), .rd_data(rd_data), .dump_count(dump_count),
    .dump_busy(dump_busy), .dump_done(dump_done), .overflow(overflow),
    .status_word(status_word), .status_vld(status_vld), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue a command (caller sits just after a negedge) and wait for its push.
  task automatic send_cmd(input logic d_en, input logic c_en);
    bit seen = 0;
    cmd_valid = 1'b1; cmd_d_en = d_en; cmd_c_en = c_en;
    cmd_err_en = 1'b0; cmd_err_ctrl = '0; cmd_sh_rst = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fsl_m_write) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) chk("cmd_push_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic rx_word(input logic ctrl, input logic [31:0] data);
    fsl_s_exists = 1'b1; fsl_s_ctrl = ctrl; fsl_s_data = data;
    @(negedge clk);
    fsl_s_exists = 1'b0; fsl_s_ctrl = 1'b0; fsl_s_data = '0;
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", a), rd_data, exp);
  endtask

  initial begin
    logic [31:0] w1 [3];
    w1[0] = 32'hA5A5_0001; w1[1] = 32'h0000_BEEF; w1[2] = 32'hF000_0001;
    rst = 1'b1; cmd_valid = 0; cmd_err_en = 0; cmd_err_ctrl = '0; cmd_sh_rst = 0;
    cmd_c_en = 0; cmd_d_en = 0; fsl_m_full = 0; fsl_s_data = '0; fsl_s_ctrl = 0;
    fsl_s_exists = 1'b1; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_read_gated", fsl_s_read, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_write", fsl_m_write, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_count", dump_count, 0);
    chk("rst_m_data", fsl_m_data, 0);
    fsl_s_exists = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Basic command: d_en=1, c_en=1
    cmd_valid = 1; cmd_d_en = 1; cmd_c_en = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("cmd1_write", fsl_m_write, 1);
    chk("cmd1_data", fsl_m_data, 32'h0001_8001);
    chk("cmd1_ctrl", fsl_m_ctrl, 0);
    chk("cmd1_ready_low", cmd_ready, 0);
    chk("cmd1_busy_pre", dump_busy, 0);
    @(negedge clk);
    chk("cmd1_write_once", fsl_m_write, 0);
    chk("cmd1_busy", dump_busy, 1);
    chk("cmd1_ready", cmd_ready, 1);

    // Back-pressure: full held for 5 cycles after accept
    fsl_m_full = 1; cmd_valid = 1; cmd_d_en = 1; cmd_c_en = 0;
    cmd_err_en = 1; cmd_err_ctrl = 12'hABC; cmd_sh_rst = 1;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("full_no_write", fsl_m_write, 0);
      chk("full_ready_low", cmd_ready, 0);
      @(negedge clk);
    end
    fsl_m_full = 0;
    #1;
    chk("full_release_write", fsl_m_write, 1);
    chk("full_release_data", fsl_m_data, 32'h0001_6AF3);
    @(negedge clk);
    chk("full_write_once", fsl_m_write, 0);
    cmd_err_en = 0; cmd_err_ctrl = '0; cmd_sh_rst = 0;

    // Dump of three words with a status word mid-stream
    rx_word(0, 32'hF000_0001);
    chk("start_busy", dump_busy, 1);
    chk("start_count", dump_count, 0);
    for (int i = 0; i < 3; i++) rx_word(0, w1[i]);
    chk("dump_count3", dump_count, 3);
    rx_word(1, 32'hDEAD_1234);
    chk("status_vld", status_vld, 1);
    chk("status_word", status_word, 32'hDEAD_1234);
    chk("status_count", dump_count, 3);
    @(negedge clk);
    chk("status_vld_pulse", status_vld, 0);
    rx_word(1, 32'hF000_0002);
    chk("done_flag", dump_done, 1);
    chk("done_busy", dump_busy, 0);
    chk("done_count", dump_count, 3);
    for (int i = 0; i < 3; i++) rd_chk(AW'(i), w1[i]);
    rx_word(0, 32'h1357_9BDF);
    chk("done_ignores_data", dump_count, 3);

    // Overflow: 6 words into a 4-word buffer
    send_cmd(1, 0);
    chk("rearm_busy", dump_busy, 1);
    chk("rearm_done", dump_done, 0);
    chk("rearm_count", dump_count, 0);
    rx_word(0, 32'hF000_0001);
    for (int i = 0; i < 6; i++) rx_word(0, 32'hC0DE_0000 + i);
    chk("ovf_count", dump_count, 4);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) rd_chk(AW'(i), 32'hC0DE_0000 + i);
    send_cmd(1, 0);
    chk("ovf_clr_count", dump_count, 0);
    chk("ovf_clr_flag", overflow, 0);

    // Watchdog behaviour: START then silence
    rx_word(0, 32'hF000_0001);
    repeat (20) @(negedge clk);
`ifdef SHDW_RX_TIMEOUT_EN
    chk("tmo_flag", timeout, 1);
    chk("tmo_idle", dump_busy, 0);
`else
    chk("no_tmo_flag", timeout, 0);
    chk("no_tmo_busy", dump_busy, 1);
`endif
    send_cmd(0, 0);
    chk("cmd_off_idle", dump_busy, 0);
    chk("cmd_off_done", dump_done, 0);

    // Reset mid-dump
    send_cmd(1, 0);
    rx_word(0, 32'hF000_0001);
    rx_word(0, 32'h2222_2222);
    chk("pre_rst_count", dump_count, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_count", dump_count, 0);
    chk("mid_rst_busy", dump_busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
